// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
//
// Purpose:
//    FIFO controller for an external simple-dual-port block RAM with a
//    one-cycle read latency. Writes go straight to the BRAM. Reads are
//    prefetched into a two-entry output buffer so the read side can stream one
//    word per cycle with no bubbles. If the output buffer is empty, returning
//    read data is bypassed to out_data_o in the same cycle. The first word
//    appears two cycles after it is pushed.
//
// Optional feature:
//    Define BRAM_FIFO_CTRL_ALMOST_FULL_EN to add parameter AF_THR (default
//    DEPTH-4) and output almost_full_o = (bram_occ >= AF_THR). With the macro
//    undefined, neither the parameter nor the port exists.
//
// Parameters:
//    DATA_WIDTH     word width (matches the BRAM data width)
//    DEPTH          number of BRAM entries, a power of two and >= 4
//
// Ports:
//    clk_i, rst_ni                      clock, async active-low reset
//    in_valid_i / in_ready_o            write-side handshake
//    in_data_i                          write-side data
//    out_valid_o / out_ready_i          read-side handshake
//    out_data_o                         read-side data (oldest word)
//    bram_we_o, bram_wr_addr_o          BRAM write strobe and address
//    bram_data_o                        BRAM write data
//    bram_en_o, bram_rd_addr_o          BRAM read enable and address
//    bram_data_i                        BRAM read data, valid 1 cycle after en
//    count_o                            total words held (BRAM + flight + buf)
//    empty_o, full_o                    status flags
//    almost_full_o                      (optional) BRAM occupancy >= AF_THR
// -----------------------------------------------------------------------------
module bram_fifo_ctrl #(
   parameter int  DATA_WIDTH = 64,
   parameter int  DEPTH      = 1024,
`ifdef BRAM_FIFO_CTRL_ALMOST_FULL_EN
   parameter int  AF_THR     = DEPTH - 4,
`endif
   localparam int AW         = $clog2(DEPTH),
   localparam int CW         = $clog2(DEPTH + 3)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   // write side
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,

   // read side
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,

   // BRAM interface
   output logic [AW-1:0]         bram_wr_addr_o,
   output logic [AW-1:0]         bram_rd_addr_o,
   output logic [DATA_WIDTH-1:0] bram_data_o,
   output logic                  bram_we_o,
   output logic                  bram_en_o,
   input  logic [DATA_WIDTH-1:0] bram_data_i,

   // status
   output logic [CW-1:0]         count_o,
   output logic                  empty_o,
`ifdef BRAM_FIFO_CTRL_ALMOST_FULL_EN
   output logic                  almost_full_o,
`endif
   output logic                  full_o
);

   localparam logic [AW:0] OCC_MAX = (AW + 1)'(DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_bram_occ;    // written, not yet read from BRAM
   logic                  r_inflight;    // read issued last cycle
   logic [1:0]            r_buf_cnt;     // output buffer occupancy, 0..2
   logic [DATA_WIDTH-1:0] r_buf0;        // oldest buffered word
   logic [DATA_WIDTH-1:0] r_buf1;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_rd_issue;
   logic [2:0]            w_held_after_pop;
   logic [1:0]            w_buf_cnt_nxt;
   logic [DATA_WIDTH-1:0] w_buf0_nxt;
   logic [DATA_WIDTH-1:0] w_buf1_nxt;

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   assign in_ready_o  = (r_bram_occ < OCC_MAX);
   assign full_o      = ~in_ready_o;

   // The write strobe is combinational from in_valid_i, so it is gated with
   // rst_ni to keep the BRAM quiet while reset is held even though in_ready_o
   // already reads 1 at that point.
   assign w_push      = in_valid_i & in_ready_o & rst_ni;

   assign out_valid_o = (r_buf_cnt != 2'd0) | r_inflight;
   assign w_pop       = out_valid_o & out_ready_i;

   // Words that will still sit in the buffer / flight after this cycle's pop.
   // A pop implies at least one such word exists, so this cannot underflow.
   assign w_held_after_pop = {1'b0, r_buf_cnt} + {2'b00, r_inflight}
                           - {2'b00, w_pop};

   // Only prefetch when the buffer has room for the returning word; the read
   // pointer only ever trails entries already counted in r_bram_occ, so a read
   // never targets the address being written in the same cycle.
   assign w_rd_issue = (r_bram_occ != '0) && (w_held_after_pop < 3'd2);

   // ---------------------------------------------------------------------------
   // BRAM ports
   // ---------------------------------------------------------------------------
   assign bram_we_o      = w_push;
   assign bram_data_o    = in_data_i;
   assign bram_wr_addr_o = r_wr_ptr;
   assign bram_en_o      = w_rd_issue;
   assign bram_rd_addr_o = r_rd_ptr;

   // ---------------------------------------------------------------------------
   // Output buffer next-state
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      w_buf_cnt_nxt = r_buf_cnt;
      w_buf0_nxt    = r_buf0;
      w_buf1_nxt    = r_buf1;
      case (r_buf_cnt)
         2'd0: begin
            // Returning word was bypassed; keep it only if it was not popped.
            if (r_inflight && !w_pop) begin
               w_buf0_nxt    = bram_data_i;
               w_buf_cnt_nxt = 2'd1;
            end
         end
         2'd1: begin
            if (w_pop) begin
               if (r_inflight) begin
                  w_buf0_nxt = bram_data_i;
               end else begin
                  w_buf_cnt_nxt = 2'd0;
               end
            end else if (r_inflight) begin
               w_buf1_nxt    = bram_data_i;
               w_buf_cnt_nxt = 2'd2;
            end
         end
         default: begin
            // Buffer full means no read was issued last cycle.
            if (w_pop) begin
               w_buf0_nxt    = r_buf1;
               w_buf_cnt_nxt = 2'd1;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_bram_occ <= '0;
         r_inflight <= 1'b0;
         r_buf_cnt  <= 2'd0;
      end else begin
         // Pointers wrap from DEPTH-1 to 0 by natural overflow of AW bits.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_bram_occ <= r_bram_occ + (AW + 1)'(w_push) - (AW + 1)'(w_rd_issue);
         r_inflight <= w_rd_issue;
         r_buf_cnt  <= w_buf_cnt_nxt;
      end
   end

   // NOTE: buffer data words carry no reset; r_buf_cnt alone says which are
   // meaningful, so clearing the data would only add reset fan-out.
   always_ff @(posedge clk_i) begin
      r_buf0 <= w_buf0_nxt;
      r_buf1 <= w_buf1_nxt;
   end

   // ---------------------------------------------------------------------------
   // Read data and status
   // ---------------------------------------------------------------------------
   assign out_data_o = (r_buf_cnt != 2'd0) ? r_buf0 : bram_data_i;

   assign count_o = CW'(r_bram_occ) + CW'(r_inflight) + CW'(r_buf_cnt);
   assign empty_o = (count_o == '0);

`ifdef BRAM_FIFO_CTRL_ALMOST_FULL_EN
   // Same timing as full_o: a compare on the registered occupancy.
   assign almost_full_o = (int'(r_bram_occ) >= AF_THR);
`endif

endmodule
